// File: rtl/ahb_mux_pkg.sv
// Shared AHB encodings, return-path mux states and select-decoding helpers.
package ahb_mux_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam int MAX_SLV = 16;

  typedef enum logic [1:0] {NORM, ERR1, ERR2} mux_state_t;

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_SLV-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SLV; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_SLV-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/ahb_mux_wdog.sv
// Wait-state watchdog: counts consecutive slave wait cycles, trips on the
// TIMEOUT-th one, and keeps a sticky record of the first offending slave.
module ahb_mux_wdog #(
  parameter int TIMEOUT   = 256,
  parameter int SLV_IDX_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wait_i,
  input  logic [SLV_IDX_W-1:0] idx_i,
  input  logic                 clr_i,
  output logic                 trip_o,
  output logic                 flag_o,
  output logic [SLV_IDX_W-1:0] slv_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 flag_q;
  logic [SLV_IDX_W-1:0] slv_q;

  assign trip_o = wait_i && (cnt_q == CW'(TIMEOUT - 1));

  // Saturating so a held-off abort can never wrap back to zero.
  always_comb begin
    cnt_d = '0;
    if (wait_i)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      slv_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      // A coincident clear still lets the new trip be recorded.
      if (trip_o && (!flag_q || clr_i)) begin
        flag_q <= 1'b1;
        slv_q  <= idx_i;
      end else if (clr_i) begin
        flag_q <= 1'b0;
        slv_q  <= '0;
      end
    end
  end

  assign flag_o = flag_q;
  assign slv_o  = slv_q;

endmodule

// File: rtl/ahb_mux_s2m_param.sv
// AHB slave-to-master return mux with built-in default slave and a
// wait-state watchdog that aborts hung slaves with a two-cycle ERROR.
module ahb_mux_s2m_param
  import ahb_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 256,
  parameter int SLV_IDX_W  = $clog2(NUM_SLAVES)
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [1:0]                   HTRANS,
  input  logic                         HREADYIn,
  input  logic [NUM_SLAVES-1:0]        HREADYS,
  input  logic [2*NUM_SLAVES-1:0]      HRESPS,
  input  logic [DATA_W*NUM_SLAVES-1:0] HRDATAS,
  output logic                         HREADYOut,
  output logic [1:0]                   HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         TimeoutFlag,
  output logic [SLV_IDX_W-1:0]         TimeoutSlv,
  input  logic                         TimeoutClr
);

  logic [NUM_SLAVES-1:0] sel_q;
  logic                  def_q, def_d;
  mux_state_t            state_q;

  logic                  load, hsel_oh, go_err, trip;
  logic                  sel_any, sel_rdy, slv_wait;
  logic [1:0]            sel_resp;
  logic [DATA_W-1:0]     sel_data;
  logic [SLV_IDX_W-1:0]  sel_idx;

  assign load    = HREADYIn && (state_q == NORM || state_q == ERR2);
  assign hsel_oh = is_onehot(MAX_SLV'(HSEL));
  assign def_d   = load ? (!hsel_oh && HTRANS[1]) : def_q;
  assign go_err  = load && def_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q   <= '0;
      def_q   <= 1'b0;
      state_q <= NORM;
    end else begin
      def_q <= def_d;
      if (load)
        sel_q <= hsel_oh ? HSEL : '0;
      else if (state_q == ERR1)
        sel_q <= '0;  // drop an aborted slave before the ERR2 cycle
      case (state_q)
        NORM:    if (go_err || trip) state_q <= ERR1;
        ERR1:    state_q <= ERR2;
        ERR2:    state_q <= go_err ? ERR1 : NORM;
        default: state_q <= NORM;
      endcase
    end
  end

  // AND-OR mux; the select register is one-hot or zero.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_resp = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_rdy  = sel_rdy  | HREADYS[i];
        sel_resp = sel_resp | HRESPS[2*i +: 2];
        sel_data = sel_data | HRDATAS[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sel_any = |sel_q;

  always_comb begin
    HREADYOut = 1'b1;
    HRESP     = RESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ERR1: begin
        HREADYOut = 1'b0;
        HRESP     = RESP_ERROR;
      end
      ERR2: HRESP = RESP_ERROR;
      default: if (sel_any) begin
        HREADYOut = sel_rdy;
        HRESP     = sel_resp;
        HRDATA    = sel_data;
      end
    endcase
  end

  assign slv_wait = (state_q == NORM) && sel_any && !sel_rdy;
  assign sel_idx  = SLV_IDX_W'(onehot_to_idx(MAX_SLV'(sel_q)));

  generate
    if (TIMEOUT > 0) begin : g_wdog
      ahb_mux_wdog #(
        .TIMEOUT   (TIMEOUT),
        .SLV_IDX_W (SLV_IDX_W)
      ) u_wdog (
        .clk_i  (HCLK),
        .rst_i  (HRESET),
        .wait_i (slv_wait),
        .idx_i  (sel_idx),
        .clr_i  (TimeoutClr),
        .trip_o (trip),
        .flag_o (TimeoutFlag),
        .slv_o  (TimeoutSlv)
      );
    end else begin : g_nowdog
      logic unused_wd;
      assign unused_wd   = TimeoutClr ^ slv_wait ^ (^sel_idx);
      assign trip        = 1'b0;
      assign TimeoutFlag = 1'b0;
      assign TimeoutSlv  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_ahb_mux_s2m_param.sv
// Directed bench for the AHB return mux: routing, default-slave ERROR,
// watchdog abort/sticky status, and reset in the middle of activity.
module tb_ahb_mux_s2m_param;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   hsel;
  logic [1:0]      htrans;
  logic            hreadyin;
  logic [NS-1:0]   hreadys;
  logic [2*NS-1:0] hresps;
  logic [DW*NS-1:0] hrdatas;
  logic            hready_out;
  logic [1:0]      hresp;
  logic [DW-1:0]   hrdata;
  logic            tflag;
  logic [1:0]      tslv;
  logic            tclr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign hreadyin = hready_out;

  ahb_mux_s2m_param #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .TIMEOUT    (TO)
  ) dut (
    .HCLK        (clk),
    .HRESET      (rst),
    .HSEL        (hsel),
    .HTRANS      (htrans),
    .HREADYIn    (hreadyin),
    .HREADYS     (hreadys),
    .HRESPS      (hresps),
    .HRDATAS     (hrdatas),
    .HREADYOut   (hready_out),
    .HRESP       (hresp),
    .HRDATA      (hrdata),
    .TimeoutFlag (tflag),
    .TimeoutSlv  (tslv),
    .TimeoutClr  (tclr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic r, input logic [1:0] rs, input logic [31:0] d);
    #1;
    chk({tag, ".rdy"},  hready_out, r);
    chk({tag, ".resp"}, hresp, rs);
    chk({tag, ".data"}, hrdata, d);
  endtask

  task automatic start(input logic [NS-1:0] hs, input logic [1:0] tr);
    hsel   = hs;
    htrans = tr;
    tick();
    hsel   = '0;
    htrans = 2'b00;
  endtask

  // Slave s holds HREADY low until the watchdog aborts; leaves state at ERR1.
  task automatic tmo(input int s, input bit clr_on_trip);
    start(NS'(1 << s), 2'b10);
    hreadys[s] = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1 && clr_on_trip) tclr = 1'b1;
      out($sformatf("tmo%0d.wait%0d", s, i), 1'b0, 2'b00, 32'hA5A5_0000 | 32'(s));
      tick();
    end
    tclr = 1'b0;
    hreadys[s] = 1'b1;
    out($sformatf("tmo%0d.err1", s), 1'b0, 2'b01, 32'h0);
  endtask

  initial begin
    rst    = 1'b1;
    hsel   = '0;
    htrans = 2'b00;
    hreadys = '1;
    hresps = '0;
    tclr   = 1'b0;
    for (int i = 0; i < NS; i++) hrdatas[DW*i +: DW] = 32'hA5A5_0000 | 32'(i);

    tick(); tick();
    rst = 1'b0;
    out("reset", 1'b1, 2'b00, 32'h0);
    chk("reset.flag", tflag, 1'b0);
    chk("reset.slv", tslv, 2'd0);

    // Plain read from slave 2, then idle.
    start(4'b0100, 2'b10);
    out("s2.read", 1'b1, 2'b00, 32'hA5A5_0002);
    tick();
    out("s2.idle", 1'b1, 2'b00, 32'h0);

    // Slave ERROR passes through without touching the watchdog.
    hresps[1:0] = 2'b01;
    start(4'b0001, 2'b10);
    out("s0.err", 1'b1, 2'b01, 32'hA5A5_0000);
    hresps[1:0] = 2'b00;
    tick();
    chk("s0.err.flag", tflag, 1'b0);

    // Unmapped NONSEQ -> default slave two-cycle ERROR.
    start(4'b0000, 2'b10);
    out("def.err1", 1'b0, 2'b01, 32'h0);
    tick();
    out("def.err2", 1'b1, 2'b01, 32'h0);
    tick();
    out("def.norm", 1'b1, 2'b00, 32'h0);
    // Unmapped IDLE -> no error.
    start(4'b0000, 2'b00);
    out("def.idle", 1'b1, 2'b00, 32'h0);

    // Multi-hot SEQ -> ERROR, no slave data leaks through.
    start(4'b0110, 2'b11);
    out("mh.err1", 1'b0, 2'b01, 32'h0);
    tick();
    out("mh.err2", 1'b1, 2'b01, 32'h0);
    tick();
    out("mh.norm", 1'b1, 2'b00, 32'h0);

    // Watchdog abort on slave 1.
    tmo(1, 1'b0);
    chk("tmo1.flag", tflag, 1'b1);
    chk("tmo1.slv", tslv, 2'd1);
    tick();
    out("tmo1.err2", 1'b1, 2'b01, 32'h0);
    tick();
    out("tmo1.norm", 1'b1, 2'b00, 32'h0);

    // Second abort keeps the first index.
    tmo(2, 1'b0);
    chk("tmo2.flag", tflag, 1'b1);
    chk("tmo2.slv", tslv, 2'd1);
    tick(); tick();
    tclr = 1'b1;
    tick();
    tclr = 1'b0;
    chk("clr.flag", tflag, 1'b0);
    chk("clr.slv", tslv, 2'd0);

    // Slave 3 waits TIMEOUT-1 cycles then completes: no abort.
    start(4'b1000, 2'b10);
    hreadys[3] = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      out($sformatf("s3.wait%0d", i), 1'b0, 2'b00, 32'hA5A5_0003);
      tick();
    end
    hreadys[3] = 1'b1;
    out("s3.done", 1'b1, 2'b00, 32'hA5A5_0003);
    tick();
    out("s3.after", 1'b1, 2'b00, 32'h0);
    chk("s3.flag", tflag, 1'b0);

    // Back-to-back default transfers: ERR2 -> ERR1 directly.
    hsel = 4'b0000; htrans = 2'b10;
    tick();
    out("b2b.err1a", 1'b0, 2'b01, 32'h0);
    tick();
    out("b2b.err2a", 1'b1, 2'b01, 32'h0);
    tick();
    hsel = 4'b0000; htrans = 2'b00;
    out("b2b.err1b", 1'b0, 2'b01, 32'h0);
    tick();
    out("b2b.err2b", 1'b1, 2'b01, 32'h0);
    tick();
    out("b2b.norm", 1'b1, 2'b00, 32'h0);

    // Trip coinciding with clear: trip wins. Then reset during ERR1.
    tmo(3, 1'b1);
    chk("tmo3.flag", tflag, 1'b1);
    chk("tmo3.slv", tslv, 2'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out("rst.err1", 1'b1, 2'b00, 32'h0);
    chk("rst.err1.flag", tflag, 1'b0);
    chk("rst.err1.slv", tslv, 2'd0);

    // Reset during a slave wait.
    start(4'b0100, 2'b10);
    hreadys[2] = 1'b0;
    out("rstw.wait", 1'b0, 2'b00, 32'hA5A5_0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hreadys[2] = 1'b1;
    out("rstw.after", 1'b1, 2'b00, 32'h0);
    chk("rstw.flag", tflag, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
